// File: rtl/led_seq_pkg.sv
// Shared constants for the LED pattern sequencer: FSM encodings, register
// map, CTRL/STATUS bit positions and the LED count of the driven core.
package led_seq_pkg;

  localparam int LED_COUNT = 4;
  localparam logic [1:0] SUB_LAST = 2'(LED_COUNT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_BLANK = 2'd3;

  localparam logic [4:0] ADDR_CTRL      = 5'h00;
  localparam logic [4:0] ADDR_STATUS    = 5'h01;
  localparam logic [4:0] ADDR_NUM_STEPS = 5'h02;

  // addr[4:3] selects the register group
  localparam logic [1:0] REGION_MISC     = 2'b00;
  localparam logic [1:0] REGION_PATTERN  = 2'b01;
  localparam logic [1:0] REGION_DURATION = 2'b10;

  localparam int CTRL_RUN_BIT  = 0;
  localparam int CTRL_LOOP_BIT = 1;

  // Number of table steps actually walked: 0 behaves as 1, anything above
  // the table depth is clamped to the depth.
  function automatic logic [3:0] effective_steps(input logic [3:0] num,
                                                 input logic [3:0] depth);
    if (num == 4'd0) begin
      return 4'd1;
    end else if (num > depth) begin
      return depth;
    end else begin
      return num;
    end
  endfunction

endpackage

// File: rtl/led_pattern_sequencer_ms_tick_gen.sv
// Millisecond tick generator: free-running divider with a synchronous clear
// so a hold period can start counting from a known phase.
module ms_tick_gen #(
  parameter int CLKS_PER_MS = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_MS - 1);

  logic [CW-1:0] count;

  // Divider counter, wraps at CLKS_PER_MS-1 and restarts on clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: CPU-programmable table of LED rate steps that is
// replayed into the 4-LED blink-rate core over its register write port.
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int CLKS_PER_MS = 100000,
  parameter int RATE_SCALE  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        m_cs,
  output logic        m_write,
  output logic [4:0]  m_addr,
  output logic [31:0] m_wr_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] SCALE = 32'(RATE_SCALE);

  // programmer-visible state
  logic        ctrl_run;
  logic        ctrl_loop;
  logic [3:0]  num_steps;
  logic [31:0] pattern  [DEPTH];
  logic [15:0] duration [DEPTH];

  // sequencer state
  logic [1:0]  state;
  logic [2:0]  step;
  logic [1:0]  sub;
  logic [15:0] ms_count;
  logic        done;
  logic        restart_pend;

  logic             bus_wr;
  logic             ctrl_wr;
  logic [IDX_W-1:0] table_idx;
  logic             idx_ok;
  logic             pat_wr;
  logic             dur_wr;
  logic             run_eff;
  logic             restart_eff;
  logic [3:0]       n_eff;
  logic             last_step;
  logic [31:0]      cur_pattern;
  logic [15:0]      cur_duration;
  logic [15:0]      dur_eff;
  logic             hold_done;
  logic [7:0]       rate_field;
  logic [31:0]      rate_scaled;
  logic             tick;
  logic             tick_clear;
  logic             fsm_clear_run;
  logic             unused_inputs;

  // reads never have side effects, so the strobe itself carries no meaning
  assign unused_inputs = read;

  assign bus_wr    = cs & write;
  assign ctrl_wr   = bus_wr && (addr == ADDR_CTRL);
  assign table_idx = addr[IDX_W-1:0];
  assign idx_ok    = ({29'd0, addr[2:0]} < 32'(DEPTH));
  assign pat_wr    = bus_wr && (addr[4:3] == REGION_PATTERN) && idx_ok;
  assign dur_wr    = bus_wr && (addr[4:3] == REGION_DURATION) && idx_ok;

  // A CTRL write in the same cycle as a decision point is honoured at once,
  // so the FSM looks at the incoming value rather than the stale register.
  assign run_eff     = ctrl_wr ? wr_data[CTRL_RUN_BIT] : ctrl_run;
  assign restart_eff = restart_pend | (ctrl_wr & wr_data[CTRL_RUN_BIT]);

  assign n_eff     = effective_steps(num_steps, 4'(DEPTH));
  assign last_step = (({1'b0, step} + 4'd1) >= n_eff);

  assign cur_pattern  = pattern[step[IDX_W-1:0]];
  assign cur_duration = duration[step[IDX_W-1:0]];
  assign dur_eff      = (cur_duration == 16'd0) ? 16'd1 : cur_duration;
  assign hold_done    = (({1'b0, ms_count} + 17'd1) >= {1'b0, dur_eff});

  assign rate_field  = cur_pattern[{sub, 3'b000} +: 8];
  assign rate_scaled = {24'd0, rate_field} * SCALE;

  // restart the ms phase on the last LOAD cycle so HOLD begins at count 0
  assign tick_clear    = (state == ST_LOAD) && (sub == SUB_LAST);
  assign fsm_clear_run = (state == ST_BLANK) && (sub == SUB_LAST) && !restart_eff;

  ms_tick_gen #(
    .CLKS_PER_MS(CLKS_PER_MS)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clear(tick_clear),
    .tick (tick)
  );

  // CPU register file; a CPU CTRL write beats the FSM's end-of-run clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_run  <= 1'b0;
      ctrl_loop <= 1'b0;
      num_steps <= 4'd0;
      for (int i = 0; i < DEPTH; i++) begin
        pattern[i]  <= 32'd0;
        duration[i] <= 16'd0;
      end
    end else begin
      if (ctrl_wr) begin
        ctrl_run  <= wr_data[CTRL_RUN_BIT];
        ctrl_loop <= wr_data[CTRL_LOOP_BIT];
      end else if (fsm_clear_run) begin
        ctrl_run <= 1'b0;
      end
      if (bus_wr && (addr == ADDR_NUM_STEPS)) begin
        num_steps <= wr_data[3:0];
      end
      if (pat_wr) begin
        pattern[table_idx] <= wr_data;
      end
      if (dur_wr) begin
        duration[table_idx] <= wr_data[15:0];
      end
    end
  end

  // Combinational read mux; unmapped locations return zero
  always_comb begin
    rd_data = 32'd0;
    case (addr[4:3])
      REGION_MISC: begin
        case (addr)
          ADDR_CTRL:      rd_data = {30'd0, ctrl_loop, ctrl_run};
          ADDR_STATUS:    rd_data = {23'd0, done, 1'b0, step, 3'd0, (state != ST_IDLE)};
          ADDR_NUM_STEPS: rd_data = {28'd0, num_steps};
          default:        rd_data = 32'd0;
        endcase
      end
      REGION_PATTERN: begin
        if (idx_ok) begin
          rd_data = pattern[table_idx];
        end else begin
          rd_data = 32'd0;
        end
      end
      REGION_DURATION: begin
        if (idx_ok) begin
          rd_data = {16'd0, duration[table_idx]};
        end else begin
          rd_data = 32'd0;
        end
      end
      default: rd_data = 32'd0;
    endcase
  end

  // Sequencer FSM: 4-write LOAD burst, ms HOLD, 4-write BLANK burst
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      step         <= 3'd0;
      sub          <= 2'd0;
      ms_count     <= 16'd0;
      done         <= 1'b0;
      restart_pend <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          restart_pend <= 1'b0;
          if (ctrl_wr && wr_data[CTRL_RUN_BIT]) begin
            state <= ST_LOAD;
            step  <= 3'd0;
            sub   <= 2'd0;
            done  <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (ctrl_wr) begin
            restart_pend <= wr_data[CTRL_RUN_BIT];
          end
          if (sub == SUB_LAST) begin
            sub <= 2'd0;
            if (restart_eff) begin
              step         <= 3'd0;
              restart_pend <= 1'b0;
              done         <= 1'b0;
            end else if (!run_eff) begin
              state <= ST_BLANK;
            end else begin
              state    <= ST_HOLD;
              ms_count <= 16'd0;
            end
          end else begin
            sub <= sub + 2'd1;
          end
        end
        ST_HOLD: begin
          sub <= 2'd0;
          if (restart_eff) begin
            state        <= ST_LOAD;
            step         <= 3'd0;
            restart_pend <= 1'b0;
            done         <= 1'b0;
          end else if (!run_eff) begin
            state <= ST_BLANK;
          end else if (tick) begin
            if (hold_done) begin
              ms_count <= 16'd0;
              if (!last_step) begin
                step  <= step + 3'd1;
                state <= ST_LOAD;
              end else if (ctrl_loop) begin
                step  <= 3'd0;
                state <= ST_LOAD;
              end else begin
                state <= ST_BLANK;
              end
            end else begin
              ms_count <= ms_count + 16'd1;
            end
          end
        end
        ST_BLANK: begin
          if (ctrl_wr) begin
            restart_pend <= wr_data[CTRL_RUN_BIT];
          end
          if (sub == SUB_LAST) begin
            sub <= 2'd0;
            if (restart_eff) begin
              state        <= ST_LOAD;
              step         <= 3'd0;
              restart_pend <= 1'b0;
            end else begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end
          end else begin
            sub <= sub + 2'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          sub   <= 2'd0;
        end
      endcase
    end
  end

  // Registered LED core write port: one write per LOAD/BLANK cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cs      <= 1'b0;
      m_write   <= 1'b0;
      m_addr    <= 5'd0;
      m_wr_data <= 32'd0;
    end else begin
      case (state)
        ST_LOAD: begin
          m_cs      <= 1'b1;
          m_write   <= 1'b1;
          m_addr    <= {3'd0, sub};
          m_wr_data <= rate_scaled;
        end
        ST_BLANK: begin
          m_cs      <= 1'b1;
          m_write   <= 1'b1;
          m_addr    <= {3'd0, sub};
          m_wr_data <= 32'd0;
        end
        default: begin
          m_cs      <= 1'b0;
          m_write   <= 1'b0;
          m_addr    <= 5'd0;
          m_wr_data <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboard bench for led_pattern_sequencer: stimulus pushes the expected
// LED core writes (cycle, addr, data); a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_led_pattern_sequencer;

  localparam int CPM   = 10;
  localparam int SCALE = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs, read, write;
  logic [4:0]  addr;
  logic [31:0] wr_data, rd_data;
  logic        m_cs, m_write;
  logic [4:0]  m_addr;
  logic [31:0] m_wr_data;

  led_pattern_sequencer #(.DEPTH(8), .CLKS_PER_MS(CPM), .RATE_SCALE(SCALE)) dut (
    .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
    .m_cs(m_cs), .m_write(m_write), .m_addr(m_addr), .m_wr_data(m_wr_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [4:0] a; logic [31:0] d; } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  int last_edge = 0;

  // Monitor: every LED core write must match the head of the scoreboard
  always @(negedge clk) begin
    if (!reset && (m_cs || m_write)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL led_write_unexpected: got cyc=%0d addr=%0d data=%0d, required no write",
                 cyc, m_addr, m_wr_data);
      end else begin
        mon_e = sb.pop_front();
        if (!m_cs || !m_write || m_addr !== mon_e.a || m_wr_data !== mon_e.d || cyc != mon_e.cyc) begin
          errors++;
          $display("FAIL led_write: got cyc=%0d cs=%0b wr=%0b addr=%0d data=%0d, required cyc=%0d addr=%0d data=%0d",
                   cyc, m_cs, m_write, m_addr, m_wr_data, mon_e.cyc, mon_e.a, mon_e.d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish within 20000 cycles");
    $fatal(1);
  end

  function automatic logic [31:0] pat3(input int k);
    return {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)};
  endfunction

  task automatic push_one(input int c, input int a, input logic [31:0] d);
    exp_t e;
    e.cyc = c; e.a = 5'(a); e.d = d;
    sb.push_back(e);
  endtask

  task automatic push_burst(input int start, input logic [31:0] pat);
    for (int i = 0; i < 4; i++) push_one(start + i, i, 32'(pat[8*i +: 8]) * 32'(SCALE));
  endtask

  task automatic push_blank(input int start);
    for (int i = 0; i < 4; i++) push_one(start + i, i, 32'd0);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, exp);
    end
  endtask

  task automatic rd_check(input logic [4:0] a, input logic [31:0] exp, input string name);
    addr = a;
    #1;
    check(name, rd_data, exp);
  endtask

  // drive one CPU write; returns at the negedge after the sampling edge
  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    @(posedge clk);
    #1;
    last_edge = cyc;
    cs = 1'b0; write = 1'b0; wr_data = 32'd0;
    @(negedge clk);
  endtask

  task automatic goto_cycle(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n;
    n = 0;
    addr = 5'h01;
    #1;
    while (rd_data[0] !== 1'b0 && n < bound) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= bound) begin
      errors++;
      $display("FAIL %s: got busy after %0d cycles, required idle", name, bound);
    end
  endtask

  task automatic drain_check(input string name);
    repeat (3) @(negedge clk);
    #1;
    check(name, 32'(sb.size()), 32'd0);
  endtask

  localparam logic [31:0] P0 = 32'h01020304, P1 = 32'h05060708, P2 = 32'h090A0B0C;
  localparam logic [31:0] Q0 = 32'h04030201, Q1 = 32'h08070605, Q2 = 32'h0C0B0A09;
  localparam logic [31:0] Q1N = 32'hFF0F0E0D;

  int n;

  initial begin
    reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0; addr = 5'd0; wr_data = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_m_cs", {31'd0, m_cs}, 32'd0);
    check("reset_m_wr_data", m_wr_data, 32'd0);
    rd_check(5'h00, 32'd0, "reset_ctrl");
    rd_check(5'h01, 32'd0, "reset_status");
    rd_check(5'h02, 32'd0, "reset_num_steps");

    // single step, 2 ms hold, no loop
    bus_write(5'h02, 32'd1);
    bus_write(5'h08, Q0);
    bus_write(5'h10, 32'd2);
    bus_write(5'h00, 32'h1); n = last_edge;
    push_burst(n + 1, Q0);
    push_blank(n + 25);
    goto_cycle(n + 10); rd_check(5'h01, 32'h001, "t1_status_hold");
    wait_idle("t1_idle", 200);
    rd_check(5'h01, 32'h100, "t1_status_done");
    rd_check(5'h00, 32'h0, "t1_ctrl_run_cleared");
    drain_check("t1_drain");

    // three steps looping, stopped mid-HOLD of second step 1
    bus_write(5'h08, P0); bus_write(5'h09, P1); bus_write(5'h0A, P2);
    bus_write(5'h10, 32'd1); bus_write(5'h11, 32'd2); bus_write(5'h12, 32'd1);
    bus_write(5'h02, 32'd3);
    bus_write(5'h00, 32'h3); n = last_edge;
    push_burst(n + 1, P0); push_burst(n + 15, P1); push_burst(n + 39, P2);
    push_burst(n + 53, P0); push_burst(n + 67, P1);
    goto_cycle(n + 10); rd_check(5'h01, 32'h001, "t2_step0");
    goto_cycle(n + 25); rd_check(5'h01, 32'h011, "t2_step1");
    goto_cycle(n + 45); rd_check(5'h01, 32'h021, "t2_step2");
    goto_cycle(n + 56); rd_check(5'h01, 32'h001, "t2_step0_again");
    goto_cycle(n + 72); rd_check(5'h01, 32'h011, "t2_step1_again");
    goto_cycle(n + 74);
    bus_write(5'h00, 32'h2);
    push_blank(n + 76);
    wait_idle("t2_idle", 200);
    rd_check(5'h01, 32'h110, "t2_status_done");
    rd_check(5'h00, 32'h2, "t2_ctrl_loop_kept");
    drain_check("t2_drain");

    // NUM_STEPS=0 runs one step, DURATION=0 holds 1 ms
    bus_write(5'h10, 32'd0);
    bus_write(5'h02, 32'd0);
    bus_write(5'h00, 32'h1); n = last_edge;
    push_burst(n + 1, P0);
    push_blank(n + 15);
    wait_idle("t3a_idle", 200);
    rd_check(5'h01, 32'h100, "t3a_status");
    drain_check("t3a_drain");

    // NUM_STEPS=15 clamps to 8 steps
    for (int k = 0; k < 8; k++) begin
      bus_write(5'(8 + k), pat3(k));
      bus_write(5'(16 + k), 32'd0);
    end
    bus_write(5'h02, 32'd15);
    bus_write(5'h00, 32'h1); n = last_edge;
    for (int k = 0; k < 8; k++) push_burst(n + 1 + 14 * k, pat3(k));
    push_blank(n + 113);
    goto_cycle(n + 102); rd_check(5'h01, 32'h071, "t3b_step7");
    wait_idle("t3b_idle", 400);
    rd_check(5'h01, 32'h170, "t3b_status");
    rd_check(5'h02, 32'hF, "t3b_num_steps_raw");
    drain_check("t3b_drain");

    // reset in the middle of the LOAD burst
    bus_write(5'h00, 32'h1); n = last_edge;
    push_one(n + 1, 0, 32'(pat3(0) & 32'hFF) * 32'(SCALE));
    push_one(n + 2, 1, 32'((pat3(0) >> 8) & 32'hFF) * 32'(SCALE));
    goto_cycle(n + 2);
    #2 reset = 1'b1;
    #1;
    check("t4_m_cs", {31'd0, m_cs}, 32'd0);
    check("t4_m_write", {31'd0, m_write}, 32'd0);
    check("t4_m_addr", {27'd0, m_addr}, 32'd0);
    check("t4_m_wr_data", m_wr_data, 32'd0);
    rd_check(5'h01, 32'd0, "t4_status");
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    rd_check(5'h08, 32'd0, "t4_pattern_cleared");
    rd_check(5'h02, 32'd0, "t4_num_steps_cleared");
    drain_check("t4_no_writes");

    // restart mid-LOAD of step 2; PATTERN[1] rewritten during step 0 HOLD
    bus_write(5'h08, Q0); bus_write(5'h09, Q1); bus_write(5'h0A, Q2);
    bus_write(5'h10, 32'd1); bus_write(5'h11, 32'd1); bus_write(5'h12, 32'd1);
    bus_write(5'h02, 32'd3);
    bus_write(5'h00, 32'h1); n = last_edge;
    push_burst(n + 1, Q0); push_burst(n + 15, Q1N); push_burst(n + 29, Q2);
    push_burst(n + 33, Q0); push_burst(n + 47, Q1N); push_burst(n + 61, Q2);
    push_blank(n + 75);
    goto_cycle(n + 5);
    bus_write(5'h09, Q1N);
    goto_cycle(n + 29);
    bus_write(5'h00, 32'h1);
    wait_idle("t5_idle", 300);
    rd_check(5'h01, 32'h120, "t5_status");
    drain_check("t5_drain");

    // unmapped reads, read-only STATUS
    rd_check(5'h1F, 32'd0, "t6_unmapped_1f");
    rd_check(5'h03, 32'd0, "t6_unmapped_03");
    rd_check(5'h18, 32'd0, "t6_unmapped_18");
    bus_write(5'h01, 32'hFFFF_FFFF);
    rd_check(5'h01, 32'h120, "t6_status_ro");
    rd_check(5'h09, Q1N, "t6_pattern1");
    rd_check(5'h12, 32'd1, "t6_duration2");
    rd_check(5'h00, 32'd0, "t6_ctrl");
    drain_check("t6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
